hazard_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage RV32I core.
- Sits beside the forwarding unit in the ID/EX control path.
- Generates the per-stage write-enable, bubble and flush controls for load-use stalls, taken-branch flushes, multi-cycle EX operations and data-memory wait states.
- Forwarding-mux selection stays in the forwarding unit; this block only freezes or advances pipeline registers.

---
 rtl/hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall sequencer: freezes, bubbles or flushes the 5-stage pipe registers.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_idex,
  input  logic             mem_read_idex,
  input  logic             branch_taken_ex,
  input  logic             mc_start_ex,
  input  logic             mc_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mc_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] LU_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_t     state_reg, state_next;
  state_t     saved_reg, saved_next;
  state_t     eff_state;
  logic [1:0] cnt_reg, cnt_next;
  logic       lu, mem_stall;
  logic       lu_cause, mc_cause, mem_cause, flush_cause;

  assign lu = mem_read_idex && (rd_idex != 5'd0) &&
              ((use_rs1_id && (rs1_id == rd_idex)) || (use_rs2_id && (rs2_id == rd_idex)));
  assign mem_stall = dmem_req && !dmem_ready;

  // The release cycle of a memory wait behaves exactly like the state it returns to.
  assign eff_state = (state_reg == MEM_WAIT) ? saved_reg : state_reg;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    state_next   = state_reg;
    saved_next   = saved_reg;
    cnt_next     = cnt_reg;
    lu_cause     = 1'b0;
    mc_cause     = 1'b0;
    mem_cause    = 1'b0;
    flush_cause  = 1'b0;

    if (mem_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      mem_cause    = 1'b1;
      state_next   = MEM_WAIT;
      if (state_reg != MEM_WAIT)
        saved_next = state_reg;
    end else begin
      state_next = eff_state;
      case (eff_state)
        RUN: begin
          if (mc_start_ex) begin
            // A result already valid on entry completes the op without a wait state.
            if (!mc_done) begin
              pc_write     = 1'b0;
              ifid_write   = 1'b0;
              idex_write   = 1'b0;
              exmem_bubble = 1'b1;
              mc_cause     = 1'b1;
              state_next   = MC_WAIT;
            end
          end else if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cause = 1'b1;
          end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            lu_cause    = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              cnt_next   = LU_INIT;
              state_next = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cause = 1'b1;
            cnt_next    = 2'd0;
            state_next  = RUN;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            lu_cause    = 1'b1;
            cnt_next    = cnt_reg - 2'd1;
            if (cnt_reg <= 2'd1)
              state_next = RUN;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_next = RUN;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mc_cause     = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end

    // Reset forces RUN defaults immediately, without waiting for a clock edge.
    if (rst) begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      lu_cause     = 1'b0;
      mc_cause     = 1'b0;
      mem_cause    = 1'b0;
      flush_cause  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      saved_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign state_o = state_reg;

  generate
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
  endgenerate

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0]       cause_vec;
  logic [CNT_W-1:0] perf_reg [4];

  assign cause_vec = {flush_cause, mem_cause, mc_cause, lu_cause};

  for (genvar gi = 0; gi < 4; gi++) begin : g_perf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        perf_reg[gi] <= '0;
      else if (cause_vec[gi] && (perf_reg[gi] != {CNT_W{1'b1}}))
        perf_reg[gi] <= perf_reg[gi] + 1'b1;
    end
  end

  assign lu_stall_cnt  = perf_reg[0];
  assign mc_stall_cnt  = perf_reg[1];
  assign mem_stall_cnt = perf_reg[2];
  assign flush_cnt     = perf_reg[3];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with 1 load-use bubble, one with 2, shared stimulus.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_idex;
  logic       use_rs1_id, use_rs2_id, mem_read_idex;
  logic       branch_taken_ex, mc_start_ex, mc_done, dmem_req, dmem_ready;

  logic       pc_write_1, ifid_write_1, idex_write_1, exmem_write_1;
  logic       idex_bubble_1, exmem_bubble_1, memwb_bubble_1, ifid_flush_1, idex_flush_1;
  logic [1:0] state_1;
  logic       pc_write_2, ifid_write_2, idex_write_2, exmem_write_2;
  logic       idex_bubble_2, exmem_bubble_2, memwb_bubble_2, ifid_flush_2, idex_flush_2;
  logic [1:0] state_2;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_c1, mc_c1, mem_c1, fl_c1, lu_c2, mc_c2, mem_c2, fl_c2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Output vector order: pc, ifid, idex, exmem writes; idex, exmem, memwb bubbles; ifid, idex flushes
  localparam logic [8:0] O_RUN   = 9'b1111_000_00;
  localparam logic [8:0] O_LU    = 9'b0011_100_00;
  localparam logic [8:0] O_MC    = 9'b0001_010_00;
  localparam logic [8:0] O_MEM   = 9'b0000_001_00;
  localparam logic [8:0] O_FLUSH = 9'b1111_000_11;

  wire [8:0] out_1 = {pc_write_1, ifid_write_1, idex_write_1, exmem_write_1,
                      idex_bubble_1, exmem_bubble_1, memwb_bubble_1, ifid_flush_1, idex_flush_1};
  wire [8:0] out_2 = {pc_write_2, ifid_write_2, idex_write_2, exmem_write_2,
                      idex_bubble_2, exmem_bubble_2, memwb_bubble_2, ifid_flush_2, idex_flush_2};

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_idex(rd_idex),
    .mem_read_idex(mem_read_idex), .branch_taken_ex(branch_taken_ex),
    .mc_start_ex(mc_start_ex), .mc_done(mc_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write_1), .ifid_write(ifid_write_1), .idex_write(idex_write_1),
    .exmem_write(exmem_write_1), .idex_bubble(idex_bubble_1), .exmem_bubble(exmem_bubble_1),
    .memwb_bubble(memwb_bubble_1), .ifid_flush(ifid_flush_1), .idex_flush(idex_flush_1),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_c1), .mc_stall_cnt(mc_c1), .mem_stall_cnt(mem_c1), .flush_cnt(fl_c1),
`endif
    .state_o(state_1)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_idex(rd_idex),
    .mem_read_idex(mem_read_idex), .branch_taken_ex(branch_taken_ex),
    .mc_start_ex(mc_start_ex), .mc_done(mc_done), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write_2), .ifid_write(ifid_write_2), .idex_write(idex_write_2),
    .exmem_write(exmem_write_2), .idex_bubble(idex_bubble_2), .exmem_bubble(exmem_bubble_2),
    .memwb_bubble(memwb_bubble_2), .ifid_flush(ifid_flush_2), .idex_flush(idex_flush_2),
`ifdef HAZARD_PERF_CNT_EN
    .lu_stall_cnt(lu_c2), .mc_stall_cnt(mc_c2), .mem_stall_cnt(mem_c2), .flush_cnt(fl_c2),
`endif
    .state_o(state_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_idex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_idex = 1'b0;
    branch_taken_ex = 1'b0; mc_start_ex = 1'b0; mc_done = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    mem_read_idex = 1'b1; rd_idex = rd; rs1_id = rd; use_rs1_id = 1'b1;
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", {23'd0, out_1}, {23'd0, O_RUN});
    check("reset_state", {30'd0, state_2}, 32'd0);
    rst = 1'b0;
    next_cycle();

    // Load-use on rs1, one bubble (dut1) and two bubbles (dut2)
    set_hazard(5'd5);
    @(negedge clk);
    check("lu1_c1_out", {23'd0, out_1}, {23'd0, O_LU});
    check("lu2_c1_out", {23'd0, out_2}, {23'd0, O_LU});
    check("lu2_c1_state", {30'd0, state_2}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("lu1_c2_out", {23'd0, out_1}, {23'd0, O_RUN});
    check("lu2_c2_out", {23'd0, out_2}, {23'd0, O_LU});
    check("lu2_c2_state", {30'd0, state_2}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("lu2_c3_out", {23'd0, out_2}, {23'd0, O_RUN});
    check("lu2_c3_state", {30'd0, state_2}, 32'd0);
    next_cycle();

    // Load writing x0 never stalls
    set_hazard(5'd0);
    @(negedge clk);
    check("lu_rd0_out", {23'd0, out_1}, {23'd0, O_RUN});
    next_cycle();
    idle_inputs();

    // Load-use via rs2 only
    mem_read_idex = 1'b1; rd_idex = 5'd9; rs2_id = 5'd9; use_rs2_id = 1'b1; rs1_id = 5'd3; use_rs1_id = 1'b1;
    @(negedge clk);
    check("lu_rs2_out", {23'd0, out_1}, {23'd0, O_LU});
    next_cycle();
    idle_inputs();
    next_cycle();

    // Branch in the second cycle of a two-bubble stall cuts it short
    set_hazard(5'd7);
    @(negedge clk);
    check("lubr_c1_out", {23'd0, out_2}, {23'd0, O_LU});
    next_cycle();
    idle_inputs();
    branch_taken_ex = 1'b1;
    @(negedge clk);
    check("lubr_c2_state", {30'd0, state_2}, 32'd1);
    check("lubr_c2_out", {23'd0, out_2}, {23'd0, O_FLUSH});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("lubr_c3_state", {30'd0, state_2}, 32'd0);
    check("lubr_c3_out", {23'd0, out_2}, {23'd0, O_RUN});
    next_cycle();

    // Branch and load-use together: branch wins
    set_hazard(5'd4);
    branch_taken_ex = 1'b1;
    @(negedge clk);
    check("br_vs_lu_out", {23'd0, out_1}, {23'd0, O_FLUSH});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("br_vs_lu_state", {30'd0, state_2}, 32'd0);
    next_cycle();

    // Multi-cycle op: four stall cycles, then the done cycle
    mc_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mc_stall%0d_out", i), {23'd0, out_1}, {23'd0, O_MC});
      check($sformatf("mc_stall%0d_state", i), {30'd0, state_1}, (i == 0) ? 32'd0 : 32'd2);
      next_cycle();
    end
    mc_done = 1'b1;
    @(negedge clk);
    check("mc_done_out", {23'd0, out_1}, {23'd0, O_RUN});
    check("mc_done_state", {30'd0, state_1}, 32'd2);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("mc_after_state", {30'd0, state_1}, 32'd0);
    next_cycle();

    // Memory wait inside a multi-cycle wait
    mc_start_ex = 1'b1;
    next_cycle();
    @(negedge clk);
    check("mcmem_pre_state", {30'd0, state_1}, 32'd2);
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mcmem_frz%0d_out", i), {23'd0, out_1}, {23'd0, O_MEM});
      check($sformatf("mcmem_frz%0d_state", i), {30'd0, state_1}, (i == 0) ? 32'd2 : 32'd3);
      next_cycle();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("mcmem_rel_out", {23'd0, out_1}, {23'd0, O_MC});
    check("mcmem_rel_state", {30'd0, state_1}, 32'd3);
    next_cycle();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    check("mcmem_back_state", {30'd0, state_1}, 32'd2);
    check("mcmem_back_out", {23'd0, out_1}, {23'd0, O_MC});
    next_cycle();
    mc_done = 1'b1;
    @(negedge clk);
    check("mcmem_done_out", {23'd0, out_1}, {23'd0, O_RUN});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("mcmem_end_state", {30'd0, state_1}, 32'd0);
    next_cycle();

    // Asynchronous reset in the middle of a load-use stall
    set_hazard(5'd6);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_state", {30'd0, state_2}, 32'd0);
    check("rst_mid_out", {23'd0, out_2}, {23'd0, O_RUN});
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst_after_out", {23'd0, out_2}, {23'd0, O_RUN});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
